// File: rtl/music_box_pkg.sv
// Shared state codes, FSM encodings and helpers for the music box mode sequencer.
package music_box_pkg;

    localparam int unsigned NUM_BUTTONS = 4;
    localparam int unsigned CODE_W      = 5;
    localparam int unsigned TIMEOUT_W   = 29;

    localparam logic [CODE_W-1:0] MB_DONOTHING     = 5'd0;
    localparam logic [CODE_W-1:0] MB_PLAYRECORDING = 5'd1;
    localparam logic [CODE_W-1:0] MB_MAKERECORDING = 5'd2;
    localparam logic [CODE_W-1:0] MB_PLAYSONG0     = 5'd3;
    localparam logic [CODE_W-1:0] MB_PLAYSONG1     = 5'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        COMPLETE = 2'd1,
        ABORT    = 2'd2,
        TIMEOUT  = 2'd3
    } exit_reason_t;

    // Button index to the state code broadcast to the state modules.
    function automatic logic [CODE_W-1:0] idx_to_code(input logic [1:0] idx);
        logic [CODE_W-1:0] code;
        code = MB_DONOTHING;
        case (idx)
            2'd0: code = MB_PLAYRECORDING;
            2'd1: code = MB_MAKERECORDING;
            2'd2: code = MB_PLAYSONG0;
            2'd3: code = MB_PLAYSONG1;
            default: code = MB_DONOTHING;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects one active-low front-panel button.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button_n,
    output logic o_press
);

    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Accept a new level only after it differs from the stable one for DEBOUNCE_CYCLES samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= i_button_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/music_box_mode_sequencer.sv
// Turns front-panel presses into the broadcast currentState code and sequences
// each session through completion, abort or watchdog timeout plus an exit hold-off.
module music_box_mode_sequencer
    import music_box_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned HOLDOFF_CYCLES  = 100_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic                   clock_50Mhz,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] button_n,
    input  logic [NUM_BUTTONS-1:0] stateComplete,
    output logic [CODE_W-1:0]      currentState,
    output logic                   busy,
    output logic [31:0]            debugString
);

    localparam int unsigned           HO_W    = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HO_W-1:0]       HO_LOAD = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0]  TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] w_press;
    logic [1:0]             w_first;
    logic                   w_hit_done;
    logic                   w_hit_press;
    logic                   w_hit_to;

    logic [NUM_BUTTONS-1:0] r_cmp_s1;
    logic [NUM_BUTTONS-1:0] r_cmp_s2;
    logic [NUM_BUTTONS-1:0] r_cmp_prev;
    logic [NUM_BUTTONS-1:0] r_done;

    seq_state_t             r_state;
    exit_reason_t           r_reason;
    logic [1:0]             r_active_idx;
    logic [CODE_W-1:0]      r_cur;
    logic                   r_busy;
    logic [TIMEOUT_W-1:0]   r_to_cnt;
    logic [HO_W-1:0]        r_ho_cnt;
    logic [7:0]             r_sessions;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cond (
            .i_clk      (clock_50Mhz),
            .i_rst_n    (reset_n),
            .i_button_n (button_n[g]),
            .o_press    (w_press[g])
        );
    end

    // stateComplete comes from the 1 kHz domain: synchronize, then pulse on the rising edge.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_s1   <= '0;
            r_cmp_s2   <= '0;
            r_cmp_prev <= '0;
            r_done     <= '0;
        end else begin
            r_cmp_s1   <= stateComplete;
            r_cmp_s2   <= r_cmp_s1;
            r_cmp_prev <= r_cmp_s2;
            r_done     <= r_cmp_s2 & ~r_cmp_prev;
        end
    end

    // Lowest pressed index wins when several buttons settle in the same cycle.
    always_comb begin
        w_first = 2'd0;
        for (int i = int'(NUM_BUTTONS) - 1; i >= 0; i--) begin
            if (w_press[i]) w_first = 2'(i);
        end
    end

    assign w_hit_done  = r_done[r_active_idx];
    assign w_hit_press = w_press[r_active_idx];
    assign w_hit_to    = (r_to_cnt == TO_LAST);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_reason     <= NONE;
            r_active_idx <= 2'd0;
            r_cur        <= MB_DONOTHING;
            r_busy       <= 1'b0;
            r_to_cnt     <= '0;
            r_ho_cnt     <= '0;
            r_sessions   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_press) begin
                        r_state      <= ACTIVE;
                        r_active_idx <= w_first;
                        r_cur        <= idx_to_code(w_first);
                        r_busy       <= 1'b1;
                        r_to_cnt     <= '0;
                        r_sessions   <= r_sessions + 8'd1;
                    end
                end
                ACTIVE: begin
                    if (w_hit_done || w_hit_press || w_hit_to) begin
                        r_state  <= HOLDOFF;
                        r_cur    <= MB_DONOTHING;
                        r_ho_cnt <= HO_LOAD;
                        if (w_hit_done)       r_reason <= COMPLETE;
                        else if (w_hit_press) r_reason <= ABORT;
                        else                  r_reason <= TIMEOUT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (r_ho_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ho_cnt <= r_ho_cnt - HO_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cur   <= MB_DONOTHING;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign currentState = r_cur;
    assign busy         = r_busy;
    assign debugString  = {8'd0, r_sessions, 7'd0, r_reason, r_state, r_cur};

endmodule

// File: tb/tb_music_box_mode_sequencer.sv
// Randomized scenario bench for music_box_mode_sequencer with small timing parameters.
module tb_music_box_mode_sequencer;

    localparam int unsigned DEB = 4;
    localparam int unsigned HO  = 8;
    localparam int unsigned TO  = 50;
    localparam int F_IDLE = 0;
    localparam int F_ACT  = 1;
    localparam int F_HOLD = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  btn_n = 4'hF;
    logic [3:0]  cmp   = 4'h0;
    logic [4:0]  cs;
    logic        busy;
    logic [31:0] dbg;

    int checks = 0;
    int errors = 0;
    int exp_sess = 0;
    int exp_reason = 0;

    always #5 clk = ~clk;

    music_box_mode_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLDOFF_CYCLES  (HO),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock_50Mhz   (clk),
        .reset_n       (rst_n),
        .button_n      (btn_n),
        .stateComplete (cmp),
        .currentState  (cs),
        .busy          (busy),
        .debugString   (dbg)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected debug word from the session model: code, FSM state, last reason, session count.
    function automatic logic [31:0] exp_dbg(input int code, input int fsm);
        logic [31:0] d;
        d = '0;
        d[4:0]   = 5'(code);
        d[6:5]   = 2'(fsm);
        d[8:7]   = 2'(exp_reason);
        d[23:16] = 8'(exp_sess % 256);
        return d;
    endfunction

    task automatic settle();
        btn_n = 4'hF;
        cmp   = 4'h0;
        step(20);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cs !== 5'd0 || busy !== 1'b0 || dbg !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got cs=%0d busy=%0b dbg=%h expected 0 0 00000000", cs, busy, dbg);
        end
        step(3);
        rst_n = 1'b1;
        step(5);
        checks++;
        if (dbg !== exp_dbg(0, F_IDLE) || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got dbg=%h busy=%0b expected %h 0", dbg, busy, exp_dbg(0, F_IDLE));
        end
    endtask

    task automatic test_normal();
        for (int k = 0; k < 2; k++) begin
            int i;
            int w;
            i = (k == 0) ? 0 : int'($urandom_range(0, 3));
            w = int'($urandom_range(2, 30));
            btn_n[i] = 1'b0;
            step(6);
            checks++;
            if (cs !== 5'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL press_early got cs=%0d busy=%0b expected 0 0", cs, busy);
            end
            step(1);
            exp_sess++;
            checks++;
            if (dbg !== exp_dbg(i + 1, F_ACT) || busy !== 1'b1) begin
                errors++;
                $display("FAIL press_latency got dbg=%h busy=%0b expected %h 1", dbg, busy, exp_dbg(i + 1, F_ACT));
            end
            btn_n[i] = 1'b1;
            step(w);
            cmp[i] = 1'b1;
            step(3);
            checks++;
            if (cs !== 5'(i + 1)) begin
                errors++;
                $display("FAIL done_early got cs=%0d expected %0d", cs, i + 1);
            end
            step(1);
            exp_reason = 1;
            checks++;
            if (dbg !== exp_dbg(0, F_HOLD) || busy !== 1'b1) begin
                errors++;
                $display("FAIL complete_exit got dbg=%h busy=%0b expected %h 1", dbg, busy, exp_dbg(0, F_HOLD));
            end
            btn_n[i] = 1'b0;
            step(HO - 1);
            checks++;
            if (busy !== 1'b1 || cs !== 5'd0) begin
                errors++;
                $display("FAIL holdoff_early got busy=%0b cs=%0d expected 1 0", busy, cs);
            end
            step(1);
            checks++;
            if (dbg !== exp_dbg(0, F_IDLE) || busy !== 1'b0) begin
                errors++;
                $display("FAIL holdoff_end got dbg=%h busy=%0b expected %h 0", dbg, busy, exp_dbg(0, F_IDLE));
            end
            step(10);
            checks++;
            if (dbg !== exp_dbg(0, F_IDLE)) begin
                errors++;
                $display("FAIL held_through_holdoff got dbg=%h expected %h", dbg, exp_dbg(0, F_IDLE));
            end
            settle();
        end
    endtask

    task automatic test_priority();
        for (int k = 0; k < 3; k++) begin
            logic [3:0] m;
            int j;
            m = (k == 0) ? 4'b1100 : 4'($urandom_range(1, 15));
            j = 0;
            for (int b = 3; b >= 0; b--) if (m[b]) j = b;
            btn_n = ~m;
            step(7);
            exp_sess++;
            checks++;
            if (dbg !== exp_dbg(j + 1, F_ACT)) begin
                errors++;
                $display("FAIL priority mask=%b got dbg=%h expected %h", m, dbg, exp_dbg(j + 1, F_ACT));
            end
            btn_n = 4'hF;
            cmp[j] = 1'b1;
            step(4);
            exp_reason = 1;
            checks++;
            if (dbg !== exp_dbg(0, F_HOLD)) begin
                errors++;
                $display("FAIL priority_exit got dbg=%h expected %h", dbg, exp_dbg(0, F_HOLD));
            end
            settle();
        end
        begin
            int g;
            g = int'($urandom_range(0, 3));
            btn_n[g] = 1'b0;
            step(3);
            btn_n[g] = 1'b1;
            step(15);
            checks++;
            if (dbg !== exp_dbg(0, F_IDLE) || busy !== 1'b0) begin
                errors++;
                $display("FAIL glitch got dbg=%h busy=%0b expected %h 0", dbg, busy, exp_dbg(0, F_IDLE));
            end
        end
    endtask

    task automatic test_abort();
        btn_n[1] = 1'b0;
        step(7);
        exp_sess++;
        checks++;
        if (dbg !== exp_dbg(2, F_ACT)) begin
            errors++;
            $display("FAIL abort_entry got dbg=%h expected %h", dbg, exp_dbg(2, F_ACT));
        end
        btn_n[1] = 1'b1;
        step(8);
        btn_n[1] = 1'b0;
        step(6);
        checks++;
        if (cs !== 5'd2) begin
            errors++;
            $display("FAIL abort_early got cs=%0d expected 2", cs);
        end
        step(1);
        exp_reason = 2;
        checks++;
        if (dbg !== exp_dbg(0, F_HOLD)) begin
            errors++;
            $display("FAIL abort_exit got dbg=%h expected %h", dbg, exp_dbg(0, F_HOLD));
        end
        settle();
        btn_n[1] = 1'b0;
        step(7);
        exp_sess++;
        btn_n[1] = 1'b1;
        step(8);
        btn_n[1] = 1'b0;
        step(3);
        cmp[1] = 1'b1;
        step(3);
        checks++;
        if (cs !== 5'd2) begin
            errors++;
            $display("FAIL coincident_early got cs=%0d expected 2", cs);
        end
        step(1);
        exp_reason = 1;
        checks++;
        if (dbg !== exp_dbg(0, F_HOLD)) begin
            errors++;
            $display("FAIL abort_vs_complete got dbg=%h expected %h", dbg, exp_dbg(0, F_HOLD));
        end
        settle();
    endtask

    task automatic test_timeout();
        int ps;
        ps = int'($urandom_range(8, 20));
        btn_n[3] = 1'b0;
        step(7);
        exp_sess++;
        checks++;
        if (dbg !== exp_dbg(4, F_ACT)) begin
            errors++;
            $display("FAIL timeout_entry got dbg=%h expected %h", dbg, exp_dbg(4, F_ACT));
        end
        btn_n[3] = 1'b1;
        for (int c = 1; c < int'(TO); c++) begin
            if (c % 4 == 0) begin
                int f;
                f = int'($urandom_range(0, 2));
                cmp[f] = ~cmp[f];
            end
            if (c == ps) btn_n[0] = 1'b0;
            if (c == ps + 10) btn_n[0] = 1'b1;
            step(1);
        end
        checks++;
        if (dbg !== exp_dbg(4, F_ACT)) begin
            errors++;
            $display("FAIL timeout_early got dbg=%h expected %h", dbg, exp_dbg(4, F_ACT));
        end
        step(1);
        exp_reason = 3;
        checks++;
        if (dbg !== exp_dbg(0, F_HOLD)) begin
            errors++;
            $display("FAIL timeout_exit got dbg=%h expected %h", dbg, exp_dbg(0, F_HOLD));
        end
        settle();
    endtask

    task automatic test_stuck_complete();
        int j;
        j = int'($urandom_range(0, 3));
        cmp[j] = 1'b1;
        step(6);
        btn_n[j] = 1'b0;
        step(7);
        exp_sess++;
        btn_n[j] = 1'b1;
        step(TO - 1);
        checks++;
        if (dbg !== exp_dbg(j + 1, F_ACT)) begin
            errors++;
            $display("FAIL stuck_no_exit got dbg=%h expected %h", dbg, exp_dbg(j + 1, F_ACT));
        end
        step(1);
        exp_reason = 3;
        checks++;
        if (dbg !== exp_dbg(0, F_HOLD)) begin
            errors++;
            $display("FAIL stuck_timeout got dbg=%h expected %h", dbg, exp_dbg(0, F_HOLD));
        end
        settle();
    endtask

    task automatic test_reset_mid();
        btn_n[2] = 1'b0;
        step(7);
        exp_sess++;
        step(int'($urandom_range(1, 20)));
        checks++;
        if (dbg !== exp_dbg(3, F_ACT)) begin
            errors++;
            $display("FAIL mid_session got dbg=%h expected %h", dbg, exp_dbg(3, F_ACT));
        end
        rst_n = 1'b0;
        #1;
        exp_sess = 0;
        exp_reason = 0;
        checks++;
        if (cs !== 5'd0 || busy !== 1'b0 || dbg !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got cs=%0d busy=%0b dbg=%h expected 0 0 00000000", cs, busy, dbg);
        end
        btn_n = 4'hF;
        step(3);
        rst_n = 1'b1;
        step(20);
        checks++;
        if (dbg !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got dbg=%h busy=%0b expected 00000000 0", dbg, busy);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_priority();
        test_abort();
        test_timeout();
        test_stuck_complete();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog run did not finish");
        $fatal(1);
    end

endmodule

// File: doc/music_box_mode_sequencer.md
# music_box_mode_sequencer

Top-level mode controller for the music box UI. It turns four front-panel buttons into a single `currentState` code that is broadcast to every state module (PlayRecording, MakeRecording, PlaySong0, PlaySong1). It waits for that module's `stateComplete`, supports abort and watchdog timeout, and returns the box to DoNothing with a guaranteed hold-off so the 1 kHz-clocked state modules observe the exit and clear themselves.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500_000 (10 ms @ 50 MHz): cycles a synchronized button level must be stable before it is accepted.
- `HOLDOFF_CYCLES`, default 100_000 (2 ms): cycles spent in DoNothing after any exit before new presses are accepted.
- `TIMEOUT_CYCLES`, default 500_000_000 (10 s): watchdog limit for one session. Width is 29 bits.

Ports:
- `clock_50Mhz`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `button_n`, in, 4: raw active-low buttons. Index i requests state code i+1.
- `stateComplete`, in, 4: completion level from state module i. Generated in the 1 kHz domain, so it is asynchronous here.
- `currentState`, out, 5: 0 = DoNothing, 1 = PlayRecording, 2 = MakeRecording, 3 = PlaySong0, 4 = PlaySong1.
- `busy`, out, 1: high whenever the FSM is not IDLE.
- `debugString`, out, 32: bits [4:0] = `currentState`, [6:5] = FSM state, [8:7] = last exit reason, [15:9] = 0, [23:16] = session count (8-bit, wraps), [31:24] = 0.

## Operation
- Each `button_n[i]`: 2-flop synchronizer, then debounce, then a one-cycle `press[i]` pulse on the debounced 1→0 transition.
- Each `stateComplete[i]`: 2-flop synchronizer, then a one-cycle `done[i]` pulse on the rising edge.
- FSM states: IDLE, ACTIVE, HOLDOFF.
- **IDLE** (`currentState` = 0):
  - Any `press` moves to ACTIVE with `currentState` = j+1, where j is the lowest pressed index.
  - `active_idx` = j. The timeout counter is cleared. The session count increments.
- **ACTIVE**: the timeout counter increments each cycle. Exit conditions, highest priority first:
  1. `done[active_idx]` → exit reason 1 (complete).
  2. `press[active_idx]` → reason 2 (abort).
  3. Counter = TIMEOUT_CYCLES−1 → reason 3 (timeout).
- Any exit sets `currentState` = 0, loads the hold-off counter and moves to HOLDOFF.
- In ACTIVE, presses on other buttons and `done` on other indices are dropped, not queued.
- **HOLDOFF** (`currentState` = 0): counts HOLDOFF_CYCLES, then goes to IDLE. All presses are dropped.
- Exit reason codes: 0 = none since reset, 1 = complete, 2 = abort, 3 = timeout.
- The exit reason and session count persist until the next exit or reset.

## Timing
- Reset, asserted at any time including mid-session: immediately drives `currentState`=0, `busy`=0, `debugString`=0, FSM=IDLE, all counters=0, synchronizer/debounce registers = released (`button_n` high, `stateComplete` low).
- Press latency: the pin must be stable low for 2 sync cycles + DEBOUNCE_CYCLES. `press` then pulses for one cycle, and `currentState`/`busy` update on the next edge.
- Completion latency: `stateComplete` rise → `done` after 3 edges → `currentState`=0 on the following edge.
- The timeout fires exactly TIMEOUT_CYCLES cycles after entry to ACTIVE.
- HOLDOFF lasts exactly HOLDOFF_CYCLES cycles. The first press can be accepted in the cycle IDLE is entered.
- `stateComplete[active_idx]` already high when ACTIVE is entered produces no `done`, because it is edge-based. Such a session ends only by abort or timeout.
- A button held through HOLDOFF does not start a new session. A fresh debounced press is required.
- Counter compares use full-width unsigned arithmetic. Nothing wraps except the session count.

## Structure
- Shared package `music_box_pkg` holds:
  - the state-code localparams `MB_DONOTHING`..`MB_PLAYSONG1` (5-bit);
  - enum `seq_state_t` {IDLE, ACTIVE, HOLDOFF} (2-bit);
  - enum `exit_reason_t` {NONE, COMPLETE, ABORT, TIMEOUT} (2-bit).
- Sub-module `button_conditioner` (sync + debounce + falling-edge pulse, parameter DEBOUNCE_CYCLES) is instantiated four times.
- The `stateComplete` synchronizers are inline.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, TIMEOUT_CYCLES=50.
1. Reset mid-ACTIVE: `currentState`=3, then `reset_n`=0 → same cycle `currentState`=0, `busy`=0, `debugString`=0. After release, IDLE is reached and no session starts without a new press.
2. Normal session: hold `button_n[0]` low → `currentState`=1 exactly 7 edges after the fall. Raise `stateComplete[0]` → `currentState`=0 4 edges later. Reason=1, count=1. A press during the next 8 cycles is ignored.
3. Priority and bounce:
   - `button_n[3:2]` fall together → `currentState`=3.
   - A glitch low for 3 cycles produces no session.
4. Abort versus complete: in session 2 (`currentState`=2), a second debounced press of button 1 → exit reason 2. The same press coincident with `done[1]` → reason 1.
5. Timeout and foreign completion: `currentState`=4 with `stateComplete[0]` toggled → no exit. After 50 cycles in ACTIVE → `currentState`=0, reason 3.
6. Completion level stuck high before entry → no exit. The session is ended only by the timeout.
